uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one simpleUARTtx instance between N byte requesters. It picks one pending requester and latches its byte. It then pulses the transmitter's start, waits for the transmitter's busy to rise and fall, and acknowledges the requester. It sits between the application byte sources and the single UART transmitter.

---
 rtl/uart_tx_arbiter.sv | 132 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between N byte requesters.
// It grants in S_IDLE, pulses tx_start, follows tx_busy up and down, then acks the requester.
module uart_tx_arbiter #(
   parameter int N            = 4,
   parameter int IDW          = 2,
   parameter int BUSY_TIMEOUT = 15
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   input  logic [8*N-1:0] req_data,
   output logic [N-1:0]   ack,
   output logic [7:0]     tx_data,
   output logic           tx_start,
   input  logic           tx_busy,
   output logic           active,
   output logic [IDW-1:0] grant_id,
   output logic           fault,
   output logic [2:0]     dbg_state
);

   // Handshakes: req[i] is a level held until its one-cycle ack[i] pulse. tx_start is a
   // one-cycle pulse; the transfer is complete once tx_busy has risen and then fallen.
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_ARM   = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_ACK   = 3'd4;

   logic [2:0]     r_state;
   logic [IDW-1:0] r_grant_id;
   logic [7:0]     r_tx_data;
   logic [N-1:0]   r_ack;
   logic           r_fault;
   logic [7:0]     r_cnt;

   logic           w_found;
   logic [IDW-1:0] w_pick;
   logic [7:0]     w_byte;
   logic [N-1:0]   w_gnt_onehot;
   logic [7:0]     w_cnt_next;

   // Scan from the requester after the last grant, so the one just served goes last.
   always_comb begin
      w_found = 1'b0;
      w_pick  = r_grant_id;
      for (int i = 1; i <= N; i++) begin
         for (int j = 0; j < N; j++) begin
            if (!w_found && req[j] && (j == (int'(r_grant_id) + i) % N)) begin
               w_found = 1'b1;
               w_pick  = IDW'(j);
            end
         end
      end
   end

   always_comb begin
      w_byte = 8'd0;
      for (int j = 0; j < N; j++) begin
         if (w_pick == IDW'(j)) w_byte = req_data[8*j +: 8];
      end
   end

   always_comb begin
      w_gnt_onehot = '0;
      for (int j = 0; j < N; j++) begin
         w_gnt_onehot[j] = (r_grant_id == IDW'(j));
      end
   end

   assign w_cnt_next = r_cnt + 8'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_grant_id <= IDW'(N-1);
         r_tx_data  <= 8'd0;
         r_ack      <= '0;
         r_fault    <= 1'b0;
         r_cnt      <= 8'd0;
      end else begin
         r_ack <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_found && !tx_busy) begin
                  r_grant_id <= w_pick;
                  r_tx_data  <= w_byte;
                  r_state    <= S_START;
               end
            end
            S_START: begin
               r_cnt   <= 8'd0;
               r_state <= S_ARM;
            end
            S_ARM: begin
               if (tx_busy) begin
                  r_state <= S_WAIT;
               end else begin
                  r_cnt <= w_cnt_next;
                  // Transmitter never went busy: drop the byte but still release the requester.
                  if (w_cnt_next == 8'(BUSY_TIMEOUT)) begin
                     r_fault <= 1'b1;
                     r_ack   <= w_gnt_onehot;
                     r_state <= S_IDLE;
                  end
               end
            end
            S_WAIT: begin
               if (!tx_busy) begin
                  r_ack   <= w_gnt_onehot;
                  r_state <= S_ACK;
               end
            end
            S_ACK: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign ack       = r_ack;
   assign tx_data   = r_tx_data;
   assign tx_start  = (r_state == S_START);
   assign active    = (r_state != S_IDLE);
   assign grant_id  = r_grant_id;
   assign fault     = r_fault;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic, all grants checked by
// a round-robin reference model feeding an expected-ack queue.
module tb_uart_tx_arbiter;

   localparam int N   = 4;
   localparam int IDW = 2;
   localparam int BT  = 15;

   logic           clk;
   logic           rst;
   logic [N-1:0]   req;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   ack;
   logic [7:0]     tx_data;
   logic           tx_start;
   logic           tx_busy;
   logic           active;
   logic [IDW-1:0] grant_id;
   logic           fault;
   logic [2:0]     dbg_state;

   uart_tx_arbiter #(.N(N), .IDW(IDW), .BUSY_TIMEOUT(BT)) dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
      .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .active(active),
      .grant_id(grant_id), .fault(fault), .dbg_state(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]     data_a [N];
   logic [IDW-1:0] exp_q [$];

   // bench-side transmitter model and stimulus controls
   logic auto_tx, force_busy, drop_en, rand_en;
   int   busy_len, busy_cnt;

   // outputs sampled 1 time unit after each rising edge
   logic           s_tx_start, s_active, s_fault;
   logic [N-1:0]   s_ack;
   logic [7:0]     s_tx_data;
   logic [IDW-1:0] s_grant;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   function automatic int rr_pick(input int last, input logic [N-1:0] r);
      logic [N-1:0] t;
      for (int k = 1; k <= N; k++) begin
         t = r >> ((last + k) % N);
         if (t[0]) return (last + k) % N;
      end
      return -1;
   endfunction

   task automatic pack();
      for (int i = 0; i < N; i++) req_data[8*i +: 8] = data_a[i];
   endtask

   // driver: one clock cycle, sample outputs, then drive transmitter and requesters
   task automatic step();
      logic [N-1:0] dropped;
      @(posedge clk);
      #1;
      s_tx_start = tx_start; s_active = active; s_fault = fault;
      s_ack = ack; s_tx_data = tx_data; s_grant = grant_id;
      #1;
      if (auto_tx) begin
         if (busy_cnt > 0) begin
            busy_cnt--;
            tx_busy = (busy_cnt != 0);
         end else if (s_tx_start) begin
            busy_cnt = (busy_len == 0) ? int'($urandom_range(1, 8)) : busy_len;
            tx_busy  = 1'b1;
         end else begin
            tx_busy = 1'b0;
         end
      end else begin
         tx_busy = force_busy;
      end
      dropped = drop_en ? (req & s_ack) : '0;
      req = req & ~dropped;
      if (rand_en) begin
         for (int i = 0; i < N; i++) begin
            if (!req[i] && !dropped[i] && $urandom_range(0, 3) == 0) begin
               data_a[i] = 8'($urandom);
               req[i]    = 1'b1;
            end
         end
      end
      pack();
   endtask

   // sel: 0 = tx_start, 1 = any ack, 2 = fault; cnt = cycles until seen
   task automatic wait_for(input int sel, input int budget, output int cnt);
      logic hit;
      hit = 1'b0;
      cnt = 0;
      while (!hit && cnt < budget) begin
         step();
         cnt++;
         case (sel)
            0:       hit = s_tx_start;
            1:       hit = (s_ack != '0);
            default: hit = s_fault;
         endcase
      end
      if (!hit) chk($sformatf("wait_timeout_sel%0d", sel), 32'd0, 32'd1);
   endtask

   task automatic do_reset();
      auto_tx = 1'b0; force_busy = 1'b0; busy_cnt = 0;
      tx_busy = 1'b0; req = '0;
      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
   endtask

   // scoreboard monitor: predicts each grant from the requests visible the cycle before
   int             m_last = N - 1;
   int             m_pick;
   logic [N-1:0]   m_prev;
   logic [IDW-1:0] m_exp;

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         m_last = N - 1;
         m_prev = req;
      end else begin
         if (tx_start) begin
            m_pick = rr_pick(m_last, m_prev);
            if (m_pick < 0) begin
               chk("mon_grant_without_req", 32'd0, 32'd1);
            end else begin
               chk("mon_tx_data", 32'(tx_data), 32'(data_a[m_pick]));
               chk("mon_grant_id", 32'(grant_id), 32'(m_pick));
               m_last = m_pick;
               exp_q.push_back(IDW'(m_pick));
            end
         end
         if (ack != '0) begin
            chk("mon_ack_onehot", 32'($onehot(ack)), 32'd1);
            chk("mon_ack_vs_start", 32'(tx_start), 32'd0);
            if (exp_q.size() == 0) begin
               chk("mon_ack_unexpected", 32'(ack), 32'd0);
            end else begin
               m_exp = exp_q.pop_front();
               chk("mon_ack_id", 32'(ack), 32'd1 << m_exp);
            end
         end
         m_prev = req;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      int seen;
      rst = 1'b1; req = '0; tx_busy = 1'b0;
      auto_tx = 1'b0; force_busy = 1'b0; drop_en = 1'b1; rand_en = 1'b0;
      busy_len = 4; busy_cnt = 0;
      for (int i = 0; i < N; i++) data_a[i] = 8'd0;
      pack();

      repeat (3) step();
      chk("reset_ack", 32'(s_ack), 32'd0);
      chk("reset_tx_start", 32'(s_tx_start), 32'd0);
      chk("reset_active", 32'(s_active), 32'd0);
      chk("reset_grant_id", 32'(s_grant), N - 1);
      chk("reset_fault", 32'(s_fault), 32'd0);
      chk("reset_tx_data", 32'(s_tx_data), 32'd0);
      rst = 1'b0;

      // single request, busy held 10 cycles
      auto_tx = 1'b1; busy_len = 10;
      data_a[0] = 8'h01; req = 4'b0001; pack();
      wait_for(0, 20, cnt);
      chk("single_start_latency", cnt, 32'd1);
      chk("single_tx_data", 32'(s_tx_data), 32'h01);
      wait_for(1, 40, cnt);
      chk("single_ack_delay", cnt, 32'd11);
      chk("single_ack", 32'(s_ack), 32'b0001);
      step();
      chk("single_idle_after_ack", 32'(s_active), 32'd0);

      // round robin with all four held high
      do_reset();
      auto_tx = 1'b1; busy_len = 3; drop_en = 1'b0;
      for (int i = 0; i < N; i++) data_a[i] = 8'hA0 + 8'(i);
      req = 4'b1111; pack();
      for (int k = 0; k < 5; k++) begin
         wait_for(0, 30, cnt);
         chk($sformatf("rr_tx_data_%0d", k), 32'(s_tx_data), 32'hA0 + (k % N));
         wait_for(1, 30, cnt);
         chk($sformatf("rr_ack_%0d", k), 32'(s_ack), 32'd1 << (k % N));
      end
      req = '0; drop_en = 1'b1;
      repeat (3) step();

      // rotation skip: after requester 1, requester 0 wins over 1
      do_reset();
      auto_tx = 1'b1; busy_len = 2;
      data_a[0] = 8'h10; data_a[1] = 8'h11; req = 4'b0010; pack();
      wait_for(0, 20, cnt);
      chk("rot_first_data", 32'(s_tx_data), 32'h11);
      wait_for(1, 30, cnt);
      req = 4'b0011;
      wait_for(0, 20, cnt);
      chk("rot_skip_data", 32'(s_tx_data), 32'h10);
      chk("rot_skip_grant", 32'(s_grant), 32'd0);
      wait_for(1, 30, cnt);
      wait_for(0, 20, cnt);
      chk("rot_second_data", 32'(s_tx_data), 32'h11);
      chk("rot_second_grant", 32'(s_grant), 32'd1);
      wait_for(1, 30, cnt);

      // busy never rises: timeout
      auto_tx = 1'b0; force_busy = 1'b0; tx_busy = 1'b0;
      data_a[2] = 8'h5A; req = 4'b0100; pack();
      wait_for(0, 20, cnt);
      wait_for(1, 40, cnt);
      chk("timeout_delay", cnt, BT + 1);
      chk("timeout_ack", 32'(s_ack), 32'b0100);
      chk("timeout_fault", 32'(s_fault), 32'd1);
      repeat (3) step();
      chk("fault_sticky", 32'(s_fault), 32'd1);

      // reset while waiting on a busy transmitter
      auto_tx = 1'b1; busy_len = 30;
      data_a[3] = 8'h77; req = 4'b1000; pack();
      wait_for(0, 20, cnt);
      repeat (4) step();
      auto_tx = 1'b0; force_busy = 1'b1; tx_busy = 1'b1;
      rst = 1'b1;
      #1;
      chk("midrst_ack", 32'(ack), 32'd0);
      chk("midrst_tx_start", 32'(tx_start), 32'd0);
      chk("midrst_active", 32'(active), 32'd0);
      chk("midrst_fault", 32'(fault), 32'd0);
      chk("midrst_grant_id", 32'(grant_id), N - 1);
      repeat (2) step();
      rst = 1'b0;
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         step();
         if (s_tx_start) seen++;
      end
      chk("midrst_no_start_while_busy", seen, 32'd0);
      auto_tx = 1'b1; busy_cnt = 0; busy_len = 3; force_busy = 1'b0; tx_busy = 1'b0;
      wait_for(0, 20, cnt);
      chk("midrst_start_after_busy", cnt, 32'd1);
      chk("midrst_tx_data", 32'(s_tx_data), 32'h77);
      wait_for(1, 30, cnt);

      // busy from outside while idle
      auto_tx = 1'b0; force_busy = 1'b1; tx_busy = 1'b1;
      data_a[0] = 8'h42; req = 4'b0001; pack();
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         step();
         if (s_tx_start) seen++;
      end
      chk("idlebusy_no_start", seen, 32'd0);
      auto_tx = 1'b1; busy_cnt = 0; busy_len = 3; force_busy = 1'b0; tx_busy = 1'b0;
      wait_for(0, 20, cnt);
      chk("idlebusy_start_latency", cnt, 32'd1);
      chk("idlebusy_tx_data", 32'(s_tx_data), 32'h42);
      wait_for(1, 30, cnt);

      // random traffic with random busy lengths
      auto_tx = 1'b1; busy_len = 0; rand_en = 1'b1;
      repeat (600) step();
      rand_en = 1'b0;
      cnt = 0;
      while (cnt < 400 && (req != '0 || s_active || exp_q.size() != 0)) begin
         step();
         cnt++;
      end
      chk("drain_req", 32'(req), 32'd0);
      chk("drain_exp_q", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
